// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns HI/LO for the 5-stage core.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             neg_res;

    always_comb begin
        signed_op = ~op[0];
        abs_a = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        abs_b = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;

        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // A set borrow bit means the trial subtraction went negative: restore.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};

        neg_res  = sign_a_q ^ sign_b_q;
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc_lo_q : acc_lo_q;
        rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                    if (start) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        sign_a_d = signed_op & operand_a[WIDTH-1];
                        sign_b_d = signed_op & operand_b[WIDTH-1];
                        a_raw_d  = operand_a;
                        acc_hi_d = '0;
                        // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                        acc_lo_d = op[1] ? abs_a : abs_b;
                        opnd_d   = op[1] ? abs_b : abs_a;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
                        acc_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opnd_q == '0) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = busy_q & (start | hilo_read | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model compared every
// cycle, plus literal expectations taken from hand-worked examples.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic          hilo_read = 1'b0;
    logic          mthi = 1'b0;
    logic          mtlo = 1'b0;
    logic [W-1:0]  mt_data = '0;
    logic          flush = 1'b0;
    logic          busy, stall_req, done;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hilo_read(hilo_read), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [2*W-1:0] model_result(input logic [1:0] o, input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic signed [W-1:0] sq, sr;
        logic [2*W-1:0] r;
        r = '0;
        case (o)
            2'd0: begin
                p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                r = p;
            end
            2'd1: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'd2: begin
                if (b == 0) r = {a, {W{1'b1}}};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    r = {sr, sq};
                end
            end
            default: begin
                if (b == 0) r = {a, {W{1'b1}}};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    int           m_rem;
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
    logic         m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (!flush) begin
                    if (mthi) m_hi <= mt_data;
                    if (mtlo) m_lo <= mt_data;
                    if (start) begin
                        {r_hi, r_lo} <= model_result(op, operand_a, operand_b);
                        m_rem <= LAT;
                    end
                end
            end else if (flush) begin
                m_rem <= 0;
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= r_hi;
                    m_lo   <= r_lo;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, (m_rem != 0)});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_stall", {31'b0, stall_req},
                  {31'b0, (m_rem != 0) && (start || hilo_read || mthi || mtlo)});
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int lat, bcnt;
        lat = 0; bcnt = 0;
        for (int n = 1; n <= LAT + 8; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
        end
        $display("%s: latency=%0d busy_cycles=%0d hi=%h lo=%h", name, lat, bcnt, hi, lo);
        check({name, "_latency"}, lat, LAT);
        check({name, "_busycnt"}, bcnt, LAT - 1);
        check({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        issue(o, a, b);
        check({name, "_busy_start"}, {31'b0, busy}, 32'd1);
        wait_done(name);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        #10;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        check_en = 1'b1;

        run_op("mult_7_m3", 2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("divu_by0", 2'd3, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF);
        run_op("div_by0", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("multu_big", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // HI/LO read and a second start held while busy.
        issue(2'd1, 32'd3, 32'd4);
        repeat (4) tick();
        hilo_read = 1'b1;
        op = 2'd3; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        #1;
        check("hold_stall", {31'b0, stall_req}, 32'd1);
        cnt = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            tick();
            if (done) break;
            cnt++;
        end
        check("hold_wait", cnt, LAT - 5);
        check("hold_done", {31'b0, done}, 32'd1);
        check("hold_stall_done", {31'b0, stall_req}, 32'd0);
        check("hold_lo", lo, 32'd12);
        check("hold_hi", hi, 32'd0);
        $display("hold: first result hi=%h lo=%h", hi, lo);
        tick();
        start = 1'b0;
        hilo_read = 1'b0;
        wait_done("held_divu");
        check("held_divu_lo", lo, 32'd14);
        check("held_divu_hi", hi, 32'd2);

        // MT writes, then a flushed multiply.
        mthi = 1'b1; mt_data = 32'hAAAA_0000;
        tick();
        mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h0000_5555;
        tick();
        mtlo = 1'b0;
        check("mt_hi", hi, 32'hAAAA_0000);
        check("mt_lo", lo, 32'h0000_5555);
        issue(2'd1, 32'd2, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        cnt = 0;
        repeat (LAT + 4) begin
            tick();
            if (done) cnt++;
        end
        $display("flush: done_pulses=%0d hi=%h lo=%h", cnt, hi, lo);
        check("flush_nodone", cnt, 32'd0);
        check("flush_hi", hi, 32'hAAAA_0000);
        check("flush_lo", lo, 32'h0000_5555);

        // Flush in IDLE wins over start and blocks the MT write.
        mthi = 1'b1; mt_data = 32'h1234_5678; op = 2'd1; start = 1'b1; flush = 1'b1;
        tick();
        mthi = 1'b0; start = 1'b0; flush = 1'b0;
        check("iflush_busy", {31'b0, busy}, 32'd0);
        check("iflush_hi", hi, 32'hAAAA_0000);

        // MTLO with start: MT lands first, FINISH overwrites both.
        mtlo = 1'b1; mt_data = 32'd77;
        issue(2'd1, 32'd5, 32'd6);
        mtlo = 1'b0;
        check("mtstart_lo", lo, 32'd77);
        wait_done("mtstart");
        check("mtstart_lo_fin", lo, 32'd30);
        check("mtstart_hi_fin", hi, 32'd0);

        // Asynchronous reset in the middle of RUN.
        issue(2'd3, 32'd50, 32'd5);
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        $display("async reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("divu_9_3", 2'd3, 32'd9, 32'd3, 32'd0, 32'd3);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
